// File: rtl/mux_32_if.sv
// Bus bundle for mux_32: data inputs, select, capture enable and results.
// With MUX32_PARITY_EN defined, a registered parity bit out_par is added.
interface mux_32_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_vld;
  logic [CNT_W-1:0] sw_cnt;
`ifdef MUX32_PARITY_EN
  logic             out_par;

  modport master (
    output in0, in1, sel, en,
    input  out, out_q, out_vld, sw_cnt, out_par
  );

  modport slave (
    input  in0, in1, sel, en,
    output out, out_q, out_vld, sw_cnt, out_par
  );
`else
  modport master (
    output in0, in1, sel, en,
    input  out, out_q, out_vld, sw_cnt
  );

  modport slave (
    input  in0, in1, sel, en,
    output out, out_q, out_vld, sw_cnt
  );
`endif
endinterface

// File: rtl/mux_32.sv
// 2:1 word mux with registered copy, valid flag and select-switch counter.
// Define MUX32_PARITY_EN to add the registered even-parity output out_par.
module mux_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_32_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] mux_w;
  logic [WIDTH-1:0] q_r;
  logic             vld_r;
  logic             sel_d;
  logic [CNT_W-1:0] cnt_r;
  logic             sw_w;

  assign mux_w = bus.sel ? bus.in1 : bus.in0;
  assign sw_w  = (bus.sel != sel_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r   <= '0;
      vld_r <= 1'b0;
    end else begin
      if (bus.en) begin
        q_r <= mux_w;
      end
      vld_r <= bus.en;
    end
  end

  // Counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_d <= 1'b0;
      cnt_r <= '0;
    end else begin
      sel_d <= bus.sel;
      if (sw_w && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign bus.out     = mux_w;
  assign bus.out_q   = q_r;
  assign bus.out_vld = vld_r;
  assign bus.sw_cnt  = cnt_r;

`ifdef MUX32_PARITY_EN
  logic par_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_r <= 1'b0;
    end else if (bus.en) begin
      par_r <= ^mux_w;
    end
  end

  assign bus.out_par = par_r;
`endif

endmodule

// File: tb/tb_mux_32.sv
// Self-checking bench for mux_32: randomized stimulus vs. behavioural model.
// A second instance with CNT_W=4 exercises counter saturation.
module tb_mux_32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_32_if #(.WIDTH(32), .CNT_W(16)) bus_a ();
  mux_32_if #(.WIDTH(32), .CNT_W(4))  bus_b ();

  mux_32 #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  mux_32 #(.WIDTH(32), .CNT_W(4)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Reference model state
  logic [31:0] m_q;
  logic        m_vld;
  logic        m_prev;
  int          m_cnt;
  int          m_cnt4;
  logic        m_par;

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic e);
    bus_a.in0 = a; bus_a.in1 = b; bus_a.sel = s; bus_a.en = e;
    bus_b.in0 = a; bus_b.in1 = b; bus_b.sel = s; bus_b.en = e;
  endtask

  // Advance one clock: update model from inputs seen at the edge.
  task automatic tick();
    logic [31:0] pick;
    pick = bus_a.sel ? bus_a.in1 : bus_a.in0;
    if (!rst_n) begin
      m_q = '0; m_vld = 1'b0; m_prev = 1'b0;
      m_cnt = 0; m_cnt4 = 0; m_par = 1'b0;
    end else begin
      if (bus_a.en) begin
        m_q = pick;
        m_par = ^pick;
      end
      m_vld = bus_a.en;
      if (bus_a.sel != m_prev) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
        m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
      end
      m_prev = bus_a.sel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive($urandom, $urandom, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (bus_a.out_q !== 32'h0) begin
      errors++; $display("FAIL reset_out_q got %h exp 0", bus_a.out_q);
    end
    checks++;
    if (bus_a.out_vld !== 1'b0) begin
      errors++; $display("FAIL reset_out_vld got %b exp 0", bus_a.out_vld);
    end
    checks++;
    if (bus_a.sw_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_sw_cnt got %0d exp 0", bus_a.sw_cnt);
    end
    checks++;
    if (bus_a.out !== bus_a.in1) begin
      errors++; $display("FAIL reset_out got %h exp %h", bus_a.out, bus_a.in1);
    end
  endtask

  task automatic test_comb();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    ta[0] = 32'hAAAAAAAA; tb[0] = 32'h55555555;
    ta[1] = 32'h12345678; tb[1] = 32'h87653321;
    ta[2] = $urandom;     tb[2] = $urandom;
    ta[3] = $urandom;     tb[3] = $urandom;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 2; s++) begin
        a = ta[i]; b = tb[i];
        drive(a, b, s[0], 1'b0);
        #1;
        exp = (s == 0) ? a : b;
        checks++;
        if (bus_a.out !== exp) begin
          errors++;
          $display("FAIL comb_out[%0d,%0d] got %h exp %h", i, s, bus_a.out, exp);
        end
      end
    end
  endtask

  task automatic test_capture();
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    drive($urandom, 32'hDEADBEEF, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus_a.out_q !== 32'hDEADBEEF) begin
      errors++; $display("FAIL cap_out_q got %h exp deadbeef", bus_a.out_q);
    end
    checks++;
    if (bus_a.out_vld !== 1'b1) begin
      errors++; $display("FAIL cap_out_vld got %b exp 1", bus_a.out_vld);
    end
    checks++;
    if (bus_a.sw_cnt !== 16'd1) begin
      errors++; $display("FAIL cap_sw_cnt got %0d exp 1", bus_a.sw_cnt);
    end
    drive($urandom, $urandom, 1'b1, 1'b0);
    tick();
    checks++;
    if (bus_a.out_q !== 32'hDEADBEEF) begin
      errors++; $display("FAIL hold_out_q got %h exp deadbeef", bus_a.out_q);
    end
    checks++;
    if (bus_a.out_vld !== 1'b0) begin
      errors++; $display("FAIL hold_out_vld got %b exp 0", bus_a.out_vld);
    end
  endtask

  task automatic test_toggle();
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive($urandom, $urandom, (i % 2 == 0), $urandom_range(0, 1) == 1);
      tick();
    end
    checks++;
    if (bus_a.sw_cnt !== 16'd10) begin
      errors++; $display("FAIL toggle10 got %0d exp 10", bus_a.sw_cnt);
    end
    checks++;
    if (bus_b.sw_cnt !== 4'd10) begin
      errors++; $display("FAIL toggle10_w4 got %0d exp 10", bus_b.sw_cnt);
    end
    for (int i = 10; i < 20; i++) begin
      drive($urandom, $urandom, (i % 2 == 0), 1'b0);
      tick();
    end
    checks++;
    if (bus_b.sw_cnt !== 4'd15) begin
      errors++; $display("FAIL sat20 got %0d exp 15", bus_b.sw_cnt);
    end
    checks++;
    if (bus_a.sw_cnt !== 16'd20) begin
      errors++; $display("FAIL toggle20 got %0d exp 20", bus_a.sw_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      drive($urandom, $urandom, (i % 2 == 0), 1'b1);
      tick();
      checks++;
      if (bus_b.sw_cnt !== 4'd15) begin
        errors++; $display("FAIL sat_hold[%0d] got %0d exp 15", i, bus_b.sw_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int i = 0; i < 200; i++) begin
      drive($urandom, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0);
      #1;
      exp = bus_a.sel ? bus_a.in1 : bus_a.in0;
      checks++;
      if (bus_a.out !== exp) begin
        errors++; $display("FAIL rnd_out[%0d] got %h exp %h", i, bus_a.out, exp);
      end
      tick();
      checks++;
      if (bus_a.out_q !== m_q || bus_a.out_vld !== m_vld) begin
        errors++;
        $display("FAIL rnd_reg[%0d] got %h/%b exp %h/%b",
                 i, bus_a.out_q, bus_a.out_vld, m_q, m_vld);
      end
      checks++;
      if (int'(bus_a.sw_cnt) != m_cnt || int'(bus_b.sw_cnt) != m_cnt4) begin
        errors++;
        $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d",
                 i, bus_a.sw_cnt, bus_b.sw_cnt, m_cnt, m_cnt4);
      end
`ifdef MUX32_PARITY_EN
      checks++;
      if (bus_a.out_par !== m_par) begin
        errors++; $display("FAIL rnd_par[%0d] got %b exp %b", i, bus_a.out_par, m_par);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    rst_n = 1'b0;
    drive($urandom, $urandom, 1'b1, 1'b1);
    tick();
    drive($urandom, $urandom, 1'b0, 1'b1);
    #1;
    exp = bus_a.in0;
    checks++;
    if (bus_a.out_q !== 32'h0 || bus_a.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_reg got %h/%b exp 0/0", bus_a.out_q, bus_a.out_vld);
    end
    checks++;
    if (bus_a.sw_cnt !== 16'd0 || bus_b.sw_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", bus_a.sw_cnt, bus_b.sw_cnt);
    end
    checks++;
    if (bus_a.out !== exp) begin
      errors++; $display("FAIL mid_rst_out got %h exp %h", bus_a.out, exp);
    end
    rst_n = 1'b1;
  endtask

`ifdef MUX32_PARITY_EN
  task automatic test_parity();
    drive(32'h00000007, 32'h0, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus_a.out_par !== 1'b1) begin
      errors++; $display("FAIL par_7 got %b exp 1", bus_a.out_par);
    end
    drive(32'h00000003, 32'h0, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus_a.out_par !== 1'b0) begin
      errors++; $display("FAIL par_3 got %b exp 0", bus_a.out_par);
    end
    drive(32'h00000001, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus_a.out_par !== 1'b0) begin
      errors++; $display("FAIL par_hold got %b exp 0", bus_a.out_par);
    end
  endtask
`endif

  initial begin
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_comb();
    test_capture();
    test_toggle();
    test_reset_mid();
    test_random();
`ifdef MUX32_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_32.md
Name: mux_32

Overview:
- 2:1 word multiplexer used in datapath select points (ALU operand B, writeback source, PC next-address choice).
- Purely combinational select path, `out = sel ? in1 : in0`, with zero latency.
- Adds a registered copy of the result, a valid flag, and a select-switch counter for pipelined consumers and debug.
- Single clock domain.

Parameters:
- WIDTH, 32, data width of in0, in1, out, out_q.
- CNT_W, 16, width of the select-switch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in0  input  WIDTH  data selected when sel=0.
- in1  input  WIDTH  data selected when sel=1.
- sel  input  1  select; 0 picks in0, 1 picks in1.
- en  input  1  capture enable for the registered stage.
- out  output  WIDTH  combinational mux result.
- out_q  output  WIDTH  registered mux result.
- out_vld  output  1  out_q holds a value captured with en=1.
- sw_cnt  output  CNT_W  number of sel transitions seen at clock edges.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- out:
  - out = in0 when sel=0; out = in1 when sel=1.
  - Purely combinational: no clock or reset dependence, and it updates within the same delta when any of in0, in1 or sel change.
  - All WIDTH bits are passed unaltered; no bit reordering.
- Reset (rst_n=0 at a rising clk edge): out_q=0, out_vld=0, sw_cnt=0, internal sel_d=0. Reset has priority over en. out is unaffected by reset.
- Registered stage, at a rising edge with rst_n=1:
  - en=1: out_q <= current out, and out_vld <= 1.
  - en=0: out_q holds, and out_vld <= 0.
  - Latency from inputs to out_q is 1 cycle.
- Switch counter:
  - sel_d <= sel every cycle when not in reset.
  - sw_cnt increments when sel != sel_d at a rising edge.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Counting is independent of en.
- First cycle after reset: sel_d=0, so sel=1 on that edge counts as one transition.
- Simultaneous events:
  - Input change and sel change in the same cycle: out_q captures the value of the newly selected input present at the edge.
  - Reset asserted mid-stream clears all registers on that edge. out keeps tracking its inputs.
- sel X/Z: out is unspecified (simulation X); no lockup of registers beyond X propagation.

Optional Feature:
- Macro: MUX32_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit, registered) = even parity (XOR reduction) of out, captured under the same en rule as out_q.
  - out_par is reset to 0 and holds when en=0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- in0=0xAAAAAAAA, in1=0x55555555, sel=0 -> out=0xAAAAAAAA immediately; sel=1 -> out=0x55555555 with no clock edge needed.
- in0=0x12345678, in1=0x87653321, sel=0 -> out=0x12345678; sel=1 -> out=0x87653321.
- rst_n=0 for 2 edges, then rst_n=1, en=1, sel=1, in1=0xDEADBEEF -> after 1 edge out_q=0xDEADBEEF, out_vld=1, sw_cnt=1. Then en=0 -> out_q holds and out_vld=0.
- Toggle sel every cycle for 10 cycles after reset, starting at 1 -> sw_cnt=10. Force near saturation (CNT_W=4, 20 toggles) -> sw_cnt=15 and it stays there.
- Assert rst_n=0 while en=1 and inputs are changing -> next edge out_q=0, out_vld=0, sw_cnt=0, while out still equals the selected input.
- With MUX32_PARITY_EN: en=1, sel=0, in0=0x00000007 -> out_par=1 after 1 edge; in0=0x00000003 -> out_par=0.
